// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD add/subtract datapath:
// FSM encoding, BCD digit constants and the digit-valid test.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    COMP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_FIX  = 4'd6;

  function automatic logic digit_ok(input logic [3:0] n);
    return n <= BCD_NINE;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// Single BCD digit adder with +6 decimal correction; shared by the
// add/subtract pass and the ten's-complement pass.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] d,
  output logic       cout
);

  logic [4:0] sum;
  logic [4:0] fixed;

  always_comb begin
    sum   = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    fixed = sum + {1'b0, BCD_FIX};
    if (sum > 5'd9) begin
      d    = fixed[3:0];
      cout = 1'b1;
    end else begin
      d    = sum[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit BCD adder/subtractor, one digit per clock LSD first, with
// sign/magnitude output for subtraction and a start/ready/done handshake.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                ready,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                carry,
  output logic                neg,
  output logic                invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS) + 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t          state, state_nx;
  logic [W-1:0]    a_r, b_r;
  logic            sub_r;
  logic [IW-1:0]   idx;
  logic [IW+1:0]   bit_pos;
  logic            cin;
  logic [3:0]      a_dig, b_dig, r_dig;
  logic [3:0]      cx, cy, cd;
  logic            ccout;

  function automatic logic ops_ok(input logic [W-1:0] x, input logic [W-1:0] y);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      ok = ok & digit_ok(x[k*4 +: 4]) & digit_ok(y[k*4 +: 4]);
    end
    return ok;
  endfunction

  assign bit_pos = {idx, 2'b00};
  assign ready   = (state == IDLE);
  assign done    = (state == DONE);

  // COMP reuses the same cell: (9 - r_i) + 0 + cin yields the ten's complement digit.
  always_comb begin
    a_dig = a_r[bit_pos +: 4];
    b_dig = b_r[bit_pos +: 4];
    r_dig = result[bit_pos +: 4];
    cx    = a_dig;
    cy    = sub_r ? (BCD_NINE - b_dig) : b_dig;
    if (state == COMP) begin
      cx = BCD_NINE - r_dig;
      cy = 4'd0;
    end
  end

  bcd_digit_cell u_cell (
    .x    (cx),
    .y    (cy),
    .cin  (cin),
    .d    (cd),
    .cout (ccout)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = ops_ok(a, b) ? RUN : DONE;
      RUN:  if (idx == LAST) state_nx = (sub_r && !ccout) ? COMP : DONE;
      COMP: if (idx == LAST) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      result  <= '0;
      carry   <= 1'b0;
      neg     <= 1'b0;
      invalid <= 1'b0;
      idx     <= '0;
      cin     <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            sub_r   <= sub;
            result  <= '0;
            carry   <= 1'b0;
            neg     <= 1'b0;
            invalid <= !ops_ok(a, b);
            idx     <= '0;
            cin     <= sub;
          end
        end
        RUN: begin
          result[bit_pos +: 4] <= cd;
          cin                  <= ccout;
          idx                  <= idx + 1'b1;
          if (idx == LAST) begin
            idx <= '0;
            cin <= 1'b1;
            if (!sub_r) carry <= ccout;
            else        neg   <= !ccout;
          end
        end
        COMP: begin
          result[bit_pos +: 4] <= cd;
          cin                  <= ccout;
          idx                  <= (idx == LAST) ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub: integer-arithmetic reference model,
// per-cycle output checker, literal vectors pinning the model.
module tb_bcd_serial_addsub;

  localparam int D = 4;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] r;
    logic        c;
    logic        n;
    logic        inv;
    int          lat;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, sub;
  logic [15:0] a, b;
  logic        ready, done, carry, neg, invalid;
  logic [15:0] result;

  int n_total = 0;
  int n_pass  = 0;

  logic        chk_en = 1'b0;
  logic        pend   = 1'b0;
  int          cyc    = 0;
  logic [15:0] exp_r  = '0;
  logic        exp_c  = 1'b0;
  logic        exp_n  = 1'b0;
  logic        exp_i  = 1'b0;
  int          exp_lat = 0;

  vec_t vecs[12];

  bcd_serial_addsub #(.DIGITS(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sub     (sub),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .done    (done),
    .result  (result),
    .carry   (carry),
    .neg     (neg),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                       output logic [15:0] r, output logic c, output logic n,
                       output logic inv, output int lat);
    int ia, ib, m, res;
    ia = 0; ib = 0; m = 1; inv = 1'b0;
    for (int k = 0; k < D; k++) begin
      if (va[k*4 +: 4] > 4'd9 || vb[k*4 +: 4] > 4'd9) inv = 1'b1;
      ia += int'(va[k*4 +: 4]) * m;
      ib += int'(vb[k*4 +: 4]) * m;
      m  *= 10;
    end
    c = 1'b0; n = 1'b0; res = 0;
    if (inv) begin
      lat = 1;
    end else if (!vs) begin
      res = ia + ib;
      c   = (res >= m);
      res = res % m;
      lat = D + 1;
    end else if (ia >= ib) begin
      res = ia - ib;
      lat = D + 1;
    end else begin
      res = ib - ia;
      n   = 1'b1;
      lat = 2 * D + 1;
    end
    r = '0;
    for (int k = 0; k < D; k++) begin
      r[k*4 +: 4] = 4'(res % 10);
      res = res / 10;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (pend) begin
        cyc++;
        if (cyc < exp_lat) begin
          chk("busy_ready", 32'(ready), 32'(1'b0));
          chk("early_done", 32'(done), 32'(1'b0));
        end else begin
          chk("done",    32'(done),    32'(1'b1));
          chk("result",  32'(result),  32'(exp_r));
          chk("carry",   32'(carry),   32'(exp_c));
          chk("neg",     32'(neg),     32'(exp_n));
          chk("invalid", 32'(invalid), 32'(exp_i));
          pend = 1'b0;
        end
      end else begin
        chk("idle_ready",   32'(ready),   32'(1'b1));
        chk("idle_done",    32'(done),    32'(1'b0));
        chk("held_result",  32'(result),  32'(exp_r));
        chk("held_carry",   32'(carry),   32'(exp_c));
        chk("held_neg",     32'(neg),     32'(exp_n));
        chk("held_invalid", 32'(invalid), 32'(exp_i));
      end
    end
  end

  task automatic do_op(input vec_t v, input bit hold_busy);
    logic [15:0] mr;
    logic        mc, mn, mi;
    int          ml;
    @(negedge clk);
    a = v.a; b = v.b; sub = v.sub; start = 1'b1;
    @(posedge clk);
    #1;
    start = hold_busy;
    if (hold_busy) begin
      a = 16'h9999; b = 16'h9999; sub = ~v.sub;
    end
    model(v.a, v.b, v.sub, mr, mc, mn, mi, ml);
    chk({v.name, "_model_r"},   32'(mr), 32'(v.r));
    chk({v.name, "_model_c"},   32'(mc), 32'(v.c));
    chk({v.name, "_model_n"},   32'(mn), 32'(v.n));
    chk({v.name, "_model_inv"}, 32'(mi), 32'(v.inv));
    chk({v.name, "_model_lat"}, 32'(ml), 32'(v.lat));
    exp_r = mr; exp_c = mc; exp_n = mn; exp_i = mi; exp_lat = ml;
    cyc = 0;
    pend = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (!pend) break;
    end
    if (pend) begin
      chk({v.name, "_timeout"}, 32'(pend), 32'(1'b0));
      pend = 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 5, "add_1234_5678"};
    vecs[1]  = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 5, "add_9999_0001"};
    vecs[2]  = '{16'h0500, 16'h0500, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 5, "add_0500_0500"};
    vecs[3]  = '{16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b0, 1'b0, 1'b0, 5, "sub_5000_1234"};
    vecs[4]  = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 5, "sub_equal"};
    vecs[5]  = '{16'h1234, 16'h5678, 1'b1, 16'h4444, 1'b0, 1'b1, 1'b0, 9, "sub_1234_5678"};
    vecs[6]  = '{16'h0000, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 9, "sub_0000_0001"};
    vecs[7]  = '{16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1, "inv_a"};
    vecs[8]  = '{16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 5, "add_after_inv"};
    vecs[9]  = '{16'h9999, 16'h0000, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b0, 5, "sub_9999_0000"};
    vecs[10] = '{16'h0000, 16'h9999, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b0, 9, "sub_0000_9999"};
    vecs[11] = '{16'h0000, 16'hF000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1, "inv_b_sub"};

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    for (int i = 0; i < 12; i++) do_op(vecs[i], 1'b0);

    // start held high through RUN and the DONE cycle with changed operands
    do_op(vecs[0], 1'b1);
    do_op(vecs[5], 1'b1);

    // reset two digits into an addition
    @(negedge clk);
    chk_en = 1'b0;
    a = 16'h1234; b = 16'h5678; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrun_ready", 32'(ready), 32'(1'b0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_r = '0; exp_c = 1'b0; exp_n = 1'b0; exp_i = 1'b0;
    @(negedge clk);
    chk("rst_ready",   32'(ready),   32'(1'b1));
    chk("rst_done",    32'(done),    32'(1'b0));
    chk("rst_result",  32'(result),  32'(16'h0000));
    chk("rst_carry",   32'(carry),   32'(1'b0));
    chk("rst_neg",     32'(neg),     32'(1'b0));
    chk("rst_invalid", 32'(invalid), 32'(1'b0));
    chk_en = 1'b1;
    repeat (10) @(negedge clk);

    do_op(vecs[3], 1'b0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
Parametrised multi-digit BCD adder/subtractor that processes one BCD digit per clock, least-significant digit first.
It generalises the single-digit BCD add with +6 correction to DIGITS digits and adds a subtract mode with sign/magnitude output. It uses a start/ready/done handshake.
It sits between operand registers (keypad/switch capture) and the 7-segment display driver in the lab datapath.

Parameters:
DIGITS, 4, number of BCD digits per operand (>=1); data width is 4*DIGITS.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when ready=1
sub  input  1  0 = A+B, 1 = A-B; captured with start
a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]
b  input  4*DIGITS  operand B, packed BCD
ready  output  1  high in IDLE; start accepted only then
done  output  1  one-cycle pulse when result is valid
result  output  4*DIGITS  BCD magnitude of the result; held until next accepted start
carry  output  1  decimal carry-out of an addition (always 0 in subtract mode)
neg  output  1  1 when a subtraction result is negative
invalid  output  1  an operand nibble was >9

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; ready=1; done=0; result=0; carry=0; neg=0; invalid=0.
  - Applies from any state and aborts any operation in progress; no done pulse is issued for the aborted operation.
- States: IDLE, RUN, COMP, DONE.
- IDLE:
  - On an edge with start=1, latch a, b and sub into internal registers.
  - Clear result, carry, neg and invalid; set digit index i=0; set cin=sub.
  - If any nibble of a or b is >9: invalid=1, go to DONE.
  - Otherwise go to RUN.
- RUN: one digit per cycle, for i=0..DIGITS-1.
  - Operand digit bd = b_i in add mode, 9-b_i in subtract mode.
  - s = a_i + bd + cin, 5-bit, range 0..19.
  - If s>9: digit = (s+6)[3:0] and cout=1. Otherwise digit = s[3:0] and cout=0.
  - Write digit into result slice i; cin <= cout.
  - After digit DIGITS-1:
    - Add mode: carry = final cout.
    - Subtract mode, final cout=1: result is non-negative, neg=0.
    - Subtract mode, final cout=0: neg=1, go to COMP.
    - Otherwise go to DONE.
- COMP: DIGITS cycles that ten's-complement the result in place, per digit i.
  - s = (9 - r_i) + cin, with cin starting at 1.
  - The same >9 correction applies; the carry is chained.
  - Then go to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE with ready=1.
  - result, carry, neg and invalid stay stable until the next accepted start.
- Latency, counted from the start-accepting edge to the cycle in which done is high:
  - Add, or subtract with a non-negative result: DIGITS+1 cycles.
  - Subtract with a negative result: 2*DIGITS+1 cycles.
  - Invalid operand: 1 cycle.
- start while ready=0 is ignored, with no queuing. Input changes to a, b and sub after capture have no effect.
- start asserted in the same cycle as done: ignored, because ready is still 0 in that cycle.
- Equal operands in subtract mode give result=0 and neg=0; there is no negative zero.
- Invalid operands: result=0, carry=0, neg=0.
- Wrap-around: in add mode the sum is modulo 10^DIGITS and the overflow is reported on carry.

Decomposition:
- Shared package bcd_pkg holds:
  - State encoding: IDLE=2'd0, RUN=2'd1, COMP=2'd2, DONE=2'd3.
  - BCD_NINE=4'd9 and BCD_FIX=4'd6.
  - Digit-valid check: nibble <= 9.
- One combinational sub-module, bcd_digit_cell:
  - Inputs: x[3:0], y[3:0], cin.
  - Outputs: d[3:0], cout.
  - Implements the >9 / +6 correction; instantiated once and shared by RUN and COMP.
- The digit index counter is ceil(log2(DIGITS))+1 bits wide.

Test Plan:
- DIGITS=4, add 1234+5678 -> result=6912, carry=0, neg=0; done 5 cycles after start; ready low for those cycles.
- add 9999+0001 -> result=0000, carry=1; 0500+0500 -> result=1000, carry=0.
- sub 5000-1234 -> result=3766, neg=0, latency 5; sub 1234-1234 -> result=0000, neg=0.
- sub 1234-5678 -> result=4444, neg=1, latency 9; sub 0000-0001 -> result=0001, neg=1.
- a=16'h12A4 with start -> invalid=1, result=0000, done 1 cycle later. A following valid start clears invalid.
- Busy and reset cases:
  - start pulsed during RUN is ignored; the first result is unaffected.
  - rst asserted mid-RUN -> next cycle ready=1, all outputs 0, no done pulse.
